// File: rtl/lzrw1_group_packer.sv
// LZRW1 group packer: collects up to 16 items (literals / copies) from the
// compressor, then emits a 16-bit control word (low byte first) followed by
// the buffered item bytes.
// Ports:
//   clock, reset       - rising-edge clock, async active-low reset
//   in_valid/in_ready  - item handshake; in_ready only while collecting
//   in_is_copy, in_literal, in_offset, in_length, in_last - item payload
//   out_valid/out_ready, out_byte, out_last - packed byte stream
//   err                - sticky flag for dropped illegal copy items
module lzrw1_group_packer #(
  parameter int unsigned GROUP_ITEMS = 16,
  parameter int unsigned BUF_BYTES   = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_copy,
  input  logic [7:0]  in_literal,
  input  logic [11:0] in_offset,
  input  logic [4:0]  in_length,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        out_last,
  output logic        err
);

  localparam int unsigned IDX_W  = $clog2(BUF_BYTES);
  localparam int unsigned CNT_W  = IDX_W + 1;
  localparam int unsigned BIT_W  = $clog2(GROUP_ITEMS);
  localparam int unsigned ITEM_W = BIT_W + 1;

  typedef enum logic [1:0] {COLLECT, EMIT_CLO, EMIT_CHI, EMIT_DATA} state_t;

  state_t                 state, state_nxt;
  logic [ITEM_W-1:0]      item_cnt, item_cnt_nxt;
  logic [CNT_W-1:0]       byte_cnt, byte_cnt_nxt;
  logic [GROUP_ITEMS-1:0] ctrl, ctrl_nxt;
  logic [IDX_W-1:0]       rd_ptr, rd_ptr_nxt;
  logic                   last_flag, last_flag_nxt;
  logic                   err_nxt;
  logic                   in_ready_nxt, out_valid_nxt, out_last_nxt;
  logic [7:0]             out_byte_nxt;
  logic                   illegal;
  logic                   wr_lo_en, wr_hi_en;
  logic [7:0]             wr_lo, wr_hi;
  logic [IDX_W-1:0]       wr_idx;
  logic [7:0]             mem [BUF_BYTES];

  assign wr_idx = byte_cnt[IDX_W-1:0];

  // Item byte buffer; contents are don't-care after reset
  always_ff @(posedge clock) begin
    if (wr_lo_en) mem[wr_idx] <= wr_lo;
    if (wr_hi_en) mem[wr_idx + IDX_W'(1)] <= wr_hi;
  end

  // State and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= COLLECT;
      item_cnt  <= '0;
      byte_cnt  <= '0;
      ctrl      <= '0;
      rd_ptr    <= '0;
      last_flag <= 1'b0;
      err       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_byte  <= 8'h00;
      out_last  <= 1'b0;
    end else begin
      state     <= state_nxt;
      item_cnt  <= item_cnt_nxt;
      byte_cnt  <= byte_cnt_nxt;
      ctrl      <= ctrl_nxt;
      rd_ptr    <= rd_ptr_nxt;
      last_flag <= last_flag_nxt;
      err       <= err_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
      out_byte  <= out_byte_nxt;
      out_last  <= out_last_nxt;
    end
  end

  // Next state, buffer writes, and next values of the registered outputs
  always_comb begin
    state_nxt     = state;
    item_cnt_nxt  = item_cnt;
    byte_cnt_nxt  = byte_cnt;
    ctrl_nxt      = ctrl;
    rd_ptr_nxt    = rd_ptr;
    last_flag_nxt = last_flag;
    err_nxt       = err;
    wr_lo_en      = 1'b0;
    wr_hi_en      = 1'b0;
    wr_lo         = 8'h00;
    wr_hi         = 8'h00;
    in_ready_nxt  = 1'b0;
    out_valid_nxt = 1'b0;
    out_byte_nxt  = 8'h00;
    out_last_nxt  = 1'b0;
    illegal       = in_is_copy &&
                    (in_length < 5'd3 || in_length > 5'd16 || in_offset == 12'd0);

    case (state)
      COLLECT: begin
        if (in_valid && in_ready) begin
          if (illegal) begin
            err_nxt = 1'b1;
          end else if (in_is_copy) begin
            wr_lo_en = 1'b1;
            wr_hi_en = 1'b1;
            wr_lo    = {in_offset[11:8], 4'(in_length - 5'd1)};
            wr_hi    = in_offset[7:0];
            byte_cnt_nxt = byte_cnt + CNT_W'(2);
            ctrl_nxt[item_cnt[BIT_W-1:0]] = 1'b1;
            item_cnt_nxt = item_cnt + ITEM_W'(1);
          end else begin
            wr_lo_en     = 1'b1;
            wr_lo        = in_literal;
            byte_cnt_nxt = byte_cnt + CNT_W'(1);
            item_cnt_nxt = item_cnt + ITEM_W'(1);
          end
          // A dropped item carrying in_last still closes the group
          if (in_last || item_cnt_nxt == ITEM_W'(GROUP_ITEMS)) begin
            state_nxt     = EMIT_CLO;
            last_flag_nxt = in_last;
          end
        end
      end
      EMIT_CLO: begin
        if (out_ready) state_nxt = EMIT_CHI;
      end
      EMIT_CHI: begin
        if (out_ready) begin
          if (byte_cnt == '0) begin
            state_nxt    = COLLECT;
            item_cnt_nxt = '0;
            ctrl_nxt     = '0;
            rd_ptr_nxt   = '0;
          end else begin
            state_nxt = EMIT_DATA;
          end
        end
      end
      EMIT_DATA: begin
        if (out_ready) begin
          if ({1'b0, rd_ptr} == byte_cnt - CNT_W'(1)) begin
            state_nxt    = COLLECT;
            item_cnt_nxt = '0;
            byte_cnt_nxt = '0;
            ctrl_nxt     = '0;
            rd_ptr_nxt   = '0;
          end else begin
            rd_ptr_nxt = rd_ptr + IDX_W'(1);
          end
        end
      end
      default: state_nxt = COLLECT;
    endcase

    // Outputs are registered, so decode them from the upcoming state
    case (state_nxt)
      COLLECT:  in_ready_nxt = 1'b1;
      EMIT_CLO: begin
        out_valid_nxt = 1'b1;
        out_byte_nxt  = ctrl_nxt[7:0];
      end
      EMIT_CHI: begin
        out_valid_nxt = 1'b1;
        out_byte_nxt  = ctrl_nxt[15:8];
        out_last_nxt  = last_flag_nxt && (byte_cnt_nxt == '0);
      end
      EMIT_DATA: begin
        out_valid_nxt = 1'b1;
        out_byte_nxt  = mem[rd_ptr_nxt];
        out_last_nxt  = last_flag_nxt &&
                        ({1'b0, rd_ptr_nxt} == byte_cnt_nxt - CNT_W'(1));
      end
      default: in_ready_nxt = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_lzrw1_group_packer.sv
// Self-checking bench for lzrw1_group_packer: directed scenarios plus
// randomized item streams compared against a group-level reference model.
module tb_lzrw1_group_packer;

  typedef struct packed {
    logic        is_copy;
    logic [7:0]  lit;
    logic [11:0] off;
    logic [4:0]  len;
    logic        last;
  } item_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_is_copy = 1'b0;
  logic [7:0]  in_literal = 8'h00;
  logic [11:0] in_offset = 12'h000;
  logic [4:0]  in_length = 5'd0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_byte;
  logic        out_last;
  logic        err;

  int checks = 0;
  int errors = 0;

  item_t      item_q[$];
  logic [7:0] exp_b[$];
  logic       exp_l[$];
  logic [7:0] obs_b[$];
  logic       obs_l[$];
  logic       ready_pat[$];
  logic       err_exp = 1'b0;
  int         hold_viol, overlap, stalls;
  bit         drv_done, dtimeout, ctimeout;

  lzrw1_group_packer dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_is_copy(in_is_copy), .in_literal(in_literal),
    .in_offset(in_offset), .in_length(in_length), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_byte(out_byte), .out_last(out_last), .err(err)
  );

  always #5 clock = ~clock;

  function automatic item_t lit_item(input logic [7:0] l, input logic last);
    item_t it;
    it = '0; it.lit = l; it.last = last;
    return it;
  endfunction

  function automatic item_t copy_item(input logic [11:0] off, input logic [4:0] len,
                                      input logic last);
    item_t it;
    it = '0; it.is_copy = 1'b1; it.off = off; it.len = len; it.last = last;
    return it;
  endfunction

  function automatic item_t rand_item(input logic last);
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 45) return lit_item(8'($urandom), last);
    if (r < 90) return copy_item(12'($urandom_range(1, 4095)), 5'($urandom_range(3, 16)), last);
    case ($urandom_range(0, 2))
      0:       return copy_item(12'($urandom_range(1, 4095)), 5'($urandom_range(0, 2)), last);
      1:       return copy_item(12'($urandom_range(1, 4095)), 5'($urandom_range(17, 31)), last);
      default: return copy_item(12'd0, 5'($urandom_range(3, 16)), last);
    endcase
  endfunction

  // Reference model: split the item list into groups and serialise each one
  function automatic void build_model();
    logic [7:0] grp[$];
    int unsigned ctrl;
    int n;
    item_t it;
    bit bad;
    exp_b.delete(); exp_l.delete();
    ctrl = 0; n = 0;
    foreach (item_q[k]) begin
      it  = item_q[k];
      bad = it.is_copy && (int'(it.len) < 3 || int'(it.len) > 16 || it.off == 12'd0);
      if (bad) begin
        err_exp = 1'b1;
      end else begin
        if (it.is_copy) begin
          ctrl = ctrl + (1 << n);
          grp.push_back(8'(int'(it.off) / 256 * 16 + int'(it.len) - 1));
          grp.push_back(8'(int'(it.off) % 256));
        end else begin
          grp.push_back(it.lit);
        end
        n++;
      end
      if (n == 16 || it.last) begin
        exp_b.push_back(8'(ctrl % 256));  exp_l.push_back(1'b0);
        exp_b.push_back(8'(ctrl / 256));  exp_l.push_back(it.last && grp.size() == 0);
        foreach (grp[j]) begin
          exp_b.push_back(grp[j]);
          exp_l.push_back(it.last && j == grp.size() - 1);
        end
        grp.delete(); ctrl = 0; n = 0;
      end
    end
  endfunction

  function automatic int first_diff();
    int n;
    n = (obs_b.size() < exp_b.size()) ? obs_b.size() : exp_b.size();
    for (int i = 0; i < n; i++)
      if (obs_b[i] !== exp_b[i] || obs_l[i] !== exp_l[i]) return i;
    if (obs_b.size() != exp_b.size()) return n;
    return -1;
  endfunction

  task automatic drive(input int gap_max);
    int w;
    foreach (item_q[k]) begin
      if (gap_max > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) @(negedge clock);
      end
      in_valid   = 1'b1;
      in_is_copy = item_q[k].is_copy;
      in_literal = item_q[k].lit;
      in_offset  = item_q[k].off;
      in_length  = item_q[k].len;
      in_last    = item_q[k].last;
      w = 0;
      while (!in_ready && w < 5000) begin
        @(negedge clock);
        w++;
      end
      if (w >= 5000) begin
        dtimeout = 1'b1;
        break;
      end
      @(negedge clock);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    drv_done = 1'b1;
  endtask

  task automatic collect(input int rmode);
    int cyc, drain;
    bit st;
    logic [7:0] pb;
    logic pl;
    cyc = 0; drain = 0; st = 1'b0; pb = 8'h00; pl = 1'b0;
    while (drain < 8) begin
      @(negedge clock);
      cyc++;
      if (st && (out_byte !== pb || out_last !== pl)) hold_viol++;
      if (ready_pat.size() > 0 && out_valid) out_ready = ready_pat.pop_front();
      else if (drain > 0 || rmode == 0)      out_ready = 1'b1;
      else                                   out_ready = ($urandom_range(0, 2) != 0);
      if (out_valid && in_ready) overlap++;
      st = out_valid && !out_ready;
      pb = out_byte; pl = out_last;
      if (st) stalls++;
      if (out_valid && out_ready) begin
        obs_b.push_back(out_byte);
        obs_l.push_back(out_last);
      end
      if (drv_done && obs_b.size() >= exp_b.size()) drain++;
      if (cyc > 20000) begin
        ctimeout = 1'b1;
        drain = 8;
      end
    end
  endtask

  task automatic run_stream(input int rmode, input int gap_max);
    obs_b.delete(); obs_l.delete();
    hold_viol = 0; overlap = 0; stalls = 0;
    drv_done = 1'b0; dtimeout = 1'b0; ctimeout = 1'b0;
    build_model();
    @(negedge clock);
    fork
      drive(gap_max);
      collect(rmode);
    join
  endtask

  task automatic test_reset;
    item_t seq[4];
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_byte !== 8'h00 ||
        out_last !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b byte=%h last=%b err=%b, need 1 0 00 0 0",
               in_ready, out_valid, out_byte, out_last, err);
    end
    seq[0] = copy_item(12'd0, 5'd4, 1'b0);
    seq[1] = lit_item(8'hA1, 1'b0);
    seq[2] = lit_item(8'hA2, 1'b0);
    seq[3] = lit_item(8'hA3, 1'b1);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      in_valid = 1'b1; in_is_copy = seq[i].is_copy; in_literal = seq[i].lit;
      in_offset = seq[i].off; in_length = seq[i].len; in_last = seq[i].last;
    end
    @(negedge clock);
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b1 || out_byte !== 8'hA1 || err !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_data: vld=%b byte=%h err=%b, need 1 a1 1", out_valid, out_byte, err);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: out_valid=%b, need 0", out_valid);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: vld=%b rdy=%b err=%b, need 0 1 0", out_valid, in_ready, err);
    end
    err_exp = 1'b0;
  endtask

  task automatic test_sixteen_literals;
    int d;
    item_q.delete();
    for (int i = 0; i < 16; i++) item_q.push_back(lit_item(8'(8'h41 + i), i == 15));
    run_stream(0, 0);
    d = first_diff();
    checks++;
    if (d !== -1 || dtimeout || ctimeout) begin
      errors++;
      $display("FAIL sixteen_model: got %0d bytes, need %0d, first diff at %0d", obs_b.size(), exp_b.size(), d);
    end
    checks++;
    if (obs_b.size() != 18) begin
      errors++;
      $display("FAIL sixteen_count: got %0d bytes, need 18", obs_b.size());
    end else if (obs_b[0] !== 8'h00 || obs_b[1] !== 8'h00 || obs_b[17] !== 8'h50 ||
                 obs_l[17] !== 1'b1 || obs_l[16] !== 1'b0) begin
      errors++;
      $display("FAIL sixteen_bytes: got %h %h .. %h last=%b, need 00 00 .. 50 last=1",
               obs_b[0], obs_b[1], obs_b[17], obs_l[17]);
    end
  endtask

  task automatic test_mixed_group;
    logic [7:0] want[6];
    int bad;
    want = '{8'h02, 8'h00, 8'h61, 8'h14, 8'h23, 8'h62};
    item_q.delete();
    item_q.push_back(lit_item(8'h61, 1'b0));
    item_q.push_back(copy_item(12'h123, 5'd5, 1'b0));
    item_q.push_back(lit_item(8'h62, 1'b1));
    run_stream(0, 0);
    bad = 0;
    if (obs_b.size() != 6) bad = 1;
    else for (int i = 0; i < 6; i++)
      if (obs_b[i] !== want[i] || obs_l[i] !== (i == 5)) bad = 1;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mixed_bytes: got %0d bytes first=%h, need 02 00 61 14 23 62 with last on 62",
               obs_b.size(), (obs_b.size() > 0) ? obs_b[0] : 8'hxx);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL mixed_err: err=%b, need 0", err);
    end
  endtask

  task automatic test_seventeen_literals;
    int d;
    item_q.delete();
    for (int i = 0; i < 17; i++) item_q.push_back(lit_item(8'(i), i == 16));
    run_stream(0, 0);
    d = first_diff();
    checks++;
    if (d !== -1 || dtimeout || ctimeout) begin
      errors++;
      $display("FAIL seventeen_model: got %0d bytes, need %0d, first diff at %0d", obs_b.size(), exp_b.size(), d);
    end
    checks++;
    if (obs_b.size() != 21) begin
      errors++;
      $display("FAIL seventeen_count: got %0d bytes, need 21", obs_b.size());
    end else if (obs_l[17] !== 1'b0 || obs_b[20] !== 8'h10 || obs_l[20] !== 1'b1) begin
      errors++;
      $display("FAIL seventeen_split: g1 last=%b, tail=%h last=%b, need 0, 10 1",
               obs_l[17], obs_b[20], obs_l[20]);
    end
    checks++;
    if (overlap != 0) begin
      errors++;
      $display("FAIL seventeen_in_ready: in_ready high during emission %0d times, need 0", overlap);
    end
  endtask

  task automatic test_back_pressure;
    int d;
    item_q.delete();
    item_q.push_back(lit_item(8'h61, 1'b0));
    item_q.push_back(copy_item(12'h123, 5'd5, 1'b0));
    item_q.push_back(lit_item(8'h62, 1'b1));
    ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    run_stream(0, 0);
    d = first_diff();
    checks++;
    if (d !== -1 || dtimeout || ctimeout) begin
      errors++;
      $display("FAIL backpressure_stream: got %0d bytes, need %0d, first diff at %0d", obs_b.size(), exp_b.size(), d);
    end
    checks++;
    if (hold_viol != 0 || stalls != 2) begin
      errors++;
      $display("FAIL backpressure_hold: changes while stalled=%0d stalls=%0d, need 0 and 2", hold_viol, stalls);
    end
  endtask

  task automatic test_illegal;
    int d;
    item_q.delete();
    item_q.push_back(copy_item(12'd0, 5'd4, 1'b0));
    item_q.push_back(lit_item(8'h7A, 1'b1));
    run_stream(0, 0);
    d = first_diff();
    checks++;
    if (d !== -1 || obs_b.size() != 3) begin
      errors++;
      $display("FAIL illegal_offset_stream: got %0d bytes, need 3 (00 00 7a), first diff at %0d", obs_b.size(), d);
    end else if (obs_b[2] !== 8'h7A || obs_l[2] !== 1'b1) begin
      errors++;
      $display("FAIL illegal_offset_bytes: got %h last=%b, need 7a last=1", obs_b[2], obs_l[2]);
    end
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL illegal_err: err=%b, need 1", err);
    end
    item_q.delete();
    item_q.push_back(copy_item(12'h010, 5'd2, 1'b1));
    run_stream(1, 0);
    d = first_diff();
    checks++;
    if (d !== -1 || obs_b.size() != 2) begin
      errors++;
      $display("FAIL illegal_empty_stream: got %0d bytes, need 2, first diff at %0d", obs_b.size(), d);
    end else if (obs_b[0] !== 8'h00 || obs_b[1] !== 8'h00 || obs_l[0] !== 1'b0 || obs_l[1] !== 1'b1) begin
      errors++;
      $display("FAIL illegal_empty_bytes: got %h/%b %h/%b, need 00/0 00/1", obs_b[0], obs_l[0], obs_b[1], obs_l[1]);
    end
  endtask

  task automatic test_random;
    int d, n;
    for (int r = 0; r < 4; r++) begin
      item_q.delete();
      n = int'($urandom_range(20, 60));
      for (int i = 0; i < n; i++) item_q.push_back(rand_item(i == n - 1));
      run_stream(1, 3);
      d = first_diff();
      checks++;
      if (d !== -1 || dtimeout || ctimeout) begin
        errors++;
        $display("FAIL random_stream[%0d]: got %0d bytes, need %0d, first diff at %0d", r, obs_b.size(), exp_b.size(), d);
      end
      checks++;
      if (hold_viol != 0 || overlap != 0) begin
        errors++;
        $display("FAIL random_handshake[%0d]: hold changes=%0d overlap=%0d, need 0 0", r, hold_viol, overlap);
      end
      checks++;
      if (err !== err_exp) begin
        errors++;
        $display("FAIL random_err[%0d]: err=%b, need %b", r, err, err_exp);
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    test_reset();
    test_sixteen_literals();
    test_mixed_group();
    test_seventeen_literals();
    test_back_pressure();
    test_illegal();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lzrw1_group_packer.md
Name: lzrw1_group_packer

Overview:
- Output stage directly downstream of compressor_top.
- Consumes the compressor's item stream (literals and copy items) and assembles LZRW1 groups: a 16-bit control word followed by up to 16 items.
- Emits the group as a byte stream, control word first.
- Buffers one group's item bytes, because the control word is only known once the group closes.

Parameters:
- GROUP_ITEMS, 16, items per group; equals control-word width. Fixed at 16 for LZRW1 format.
- BUF_BYTES, 32, item buffer depth = 2*GROUP_ITEMS.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  item present.
- in_ready  out  1  packer accepts item this cycle.
- in_is_copy  in  1  1 = copy item, 0 = literal.
- in_literal  in  8  literal byte (in_is_copy=0).
- in_offset  in  12  copy offset, 1..4095.
- in_length  in  5  copy length, 3..16.
- in_last  in  1  final item of the stream.
- out_valid  out  1  output byte present.
- out_ready  in  1  consumer accepts byte.
- out_byte  out  8  packed byte.
- out_last  out  1  final byte of the stream.
- err  out  1  sticky illegal-item flag.

Behaviour:
- Reset (reset=0, async): state=COLLECT, item_cnt=0, byte_cnt=0, ctrl=0, rd_ptr=0. Outputs: in_ready=1, out_valid=0, out_byte=0, out_last=0, err=0. Buffer contents are don't-care. Reset mid-group discards the partial group, with no output.
- Input handshake: an item transfers when in_valid && in_ready. in_ready=1 only in COLLECT.
- Literal item:
  - buf[byte_cnt] = in_literal.
  - byte_cnt += 1.
  - ctrl[item_cnt] = 0.
- Copy item:
  - buf[byte_cnt] = {in_offset[11:8], in_length-1 (4 bits)}.
  - buf[byte_cnt+1] = in_offset[7:0].
  - byte_cnt += 2.
  - ctrl[item_cnt] = 1.
- Items take control bits LSB first; bit 0 is the first item of the group.
- Illegal copy (in_length<3, in_length>16, or in_offset==0):
  - item is accepted and dropped; item_cnt is unchanged.
  - err is set, sticky until reset.
  - If the dropped item has in_last=1, the group still closes.
- Group close: on the accepted item where item_cnt becomes 16, or where in_last=1. Next state EMIT_CLO; latch last_flag=in_last.
- EMIT_CLO: out_byte=ctrl[7:0].
- EMIT_CHI: out_byte=ctrl[15:8].
- EMIT_DATA: out_byte=buf[rd_ptr]; rd_ptr advances on each handshake until rd_ptr==byte_cnt-1.
- Unused control bits of a partial group are 0.
- Output handshake:
  - out_valid=1 in all EMIT states.
  - The state advances only on out_valid && out_ready.
  - out_byte and out_last stay stable while out_ready=0.
- out_last=1 only on the final emitted byte of a group with last_flag=1.
- A closed group holding zero valid items (only dropped items, in_last=1) emits 00 00 with out_last on the second byte.
- After the final data byte handshake:
  - clear item_cnt, byte_cnt, ctrl, rd_ptr; return to COLLECT.
  - in_ready rises on the next cycle, so there is a one-cycle bubble between groups.
- Latency: first control byte is valid on the cycle after the closing item is accepted.
- Throughput: one byte per cycle with out_ready held high.
- Buffer never overflows: at most 16 items × 2 bytes = 32. byte_cnt is 6 bits; item_cnt is 5 bits.
- No input is accepted during EMIT states. Simultaneous in_valid is held off by in_ready=0.

Test Plan:
- Reset: drive reset=0 mid-EMIT_DATA, then release → out_valid=0, in_ready=1, err=0. Next group starts cleanly with no residual bytes.
- 16 literals 0x41..0x50, in_last on the 16th, out_ready=1 → bytes 00 00 41 42 … 50; out_last on 0x50; total 18 bytes.
- Single group: literal 0x61, copy(offset=0x123, length=5), literal 0x62, in_last → 02 00 61 14 23 62; out_last on 0x62.
- 17 literals 0x00..0x10, in_last on the 17th:
  - group 1 = 00 00 00..0F, out_last=0;
  - group 2 = 00 00 10, out_last on 0x10;
  - in_ready=0 throughout group-1 emission.
- Back-pressure: toggle out_ready 1,0,0,1 during control-byte emission → out_byte holds value while stalled, with no byte lost or duplicated.
- Illegal items:
  - copy(offset=0, length=4), then literal 0x7A with in_last → err=1, output 00 00 7A.
  - copy(length=2) alone with in_last → 00 00, out_last on the second byte.
